// File: rtl/count_disp_pkg.sv
// Shared definitions for the 2-digit seconds display.
// Holds active-low segment codes ({g,f,e,d,c,b,a}), the anode-off pattern,
// the digit-slot enum and a BCD-to-segment lookup.
package count_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] AN_OFF    = 2'b11;

    typedef enum logic {
        SLOT_UNITS = 1'b0,
        SLOT_TENS  = 1'b1
    } slot_e;

    // Non-decimal codes fall back to blank so a corrupt digit never lights up.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/count_seg_display_bin2bcd7.sv
// Combinational 7-bit binary to two BCD digits.
// Ports:
//   i_bin   [6:0] binary input 0..127
//   o_tens  [3:0] tens digit (valid for inputs 0..99)
//   o_units [3:0] units digit (valid for inputs 0..99)
//   o_over        input is above 99
module bin2bcd7 (
    input  logic [6:0] i_bin,
    output logic [3:0] o_tens,
    output logic [3:0] o_units,
    output logic       o_over
);

    // Range-match each decade; only one k can hit, the remainder is a
    // small subtract that fits in 4 bits.
    always_comb begin
        o_tens  = 4'd0;
        o_units = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if ((i_bin >= 7'(k * 10)) && (i_bin < 7'(k * 10 + 10))) begin
                o_tens  = 4'(k);
                o_units = 4'(i_bin - 7'(k * 10));
            end
        end
    end

    assign o_over = (i_bin > 7'd99);

endmodule

// File: rtl/count_seg_display.sv
// Two-digit multiplexed 7-segment driver for the seconds counter.
// Snapshots the count once per frame so both digits agree, scans units/tens,
// blanks a leading zero, shows dashes above 99 and blinks at/above WARN_VAL.
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   value[6:0] binary count from the counter
//   power      1 = scan and display, 0 = freeze state and blank outputs
//   seg[6:0]   active-low segments {g,f,e,d,c,b,a}, registered
//   an[1:0]    active-low anodes, an[0] units, an[1] tens, registered
module count_seg_display
    import count_disp_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int BLINK_TICKS = 250,
    parameter int WARN_VAL    = 35,
    parameter int LZ_BLANK    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] value,
    input  logic       power,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [PW-1:0] r_pcnt;
    logic [BW-1:0] r_bcnt;
    slot_e         r_digit;
    logic [6:0]    r_snap;
    logic          r_blink_phase;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;

    logic          w_tick;
    logic [3:0]    w_tens;
    logic [3:0]    w_units;
    logic          w_over;
    logic          w_blink;
    logic [6:0]    w_code;

    // Freezing on power low also freezes the slot/blink state, so a restore
    // resumes exactly where it stopped.
    assign w_tick = (r_pcnt == PW'(SCAN_DIV - 1)) && power;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt        <= '0;
            r_bcnt        <= '0;
            r_digit       <= SLOT_UNITS;
            r_snap        <= '0;
            r_blink_phase <= 1'b0;
        end else if (power) begin
            r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            if (w_tick) begin
                r_digit <= (r_digit == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
                // Sample only when entering the units slot: one frame, one value.
                if (r_digit == SLOT_TENS)
                    r_snap <= value;
                if (r_bcnt == BW'(BLINK_TICKS - 1)) begin
                    r_bcnt        <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end
        end
    end

    bin2bcd7 u_bcd (
        .i_bin   (r_snap),
        .o_tens  (w_tens),
        .o_units (w_units),
        .o_over  (w_over)
    );

    always_comb begin
        w_code = bcd_to_seg(w_units);
        if (w_over)
            w_code = SEG_DASH;
        else if (r_digit == SLOT_TENS)
            w_code = ((LZ_BLANK != 0) && (w_tens == 4'd0)) ? SEG_BLANK : bcd_to_seg(w_tens);
    end

    assign w_blink = (r_snap >= 7'(WARN_VAL)) && r_blink_phase;

    // Blanked slots keep both anodes high; a lit slot drives exactly one low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= SEG_BLANK;
            r_an  <= AN_OFF;
        end else if (!power || w_blink) begin
            r_seg <= SEG_BLANK;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= w_code;
            r_an  <= (r_digit == SLOT_UNITS) ? 2'b10 : 2'b01;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule
